// File: rtl/lib_pkg.sv
// Shared types for the load/store path: LSU state encoding, access sizes and
// the alignment rule used when a request is accepted.
package lib_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_t;

    typedef enum logic [1:0] {
        BYTE  = 2'd0,
        HALF  = 2'd1,
        WORD  = 2'd2,
        DWORD = 2'd3
    } mem_size_t;

    // An access of 2^size bytes must start on a 2^size byte boundary.
    function automatic logic is_misaligned(input logic [2:0] addr_lo, input mem_size_t size);
        case (size)
            BYTE:    return 1'b0;
            HALF:    return addr_lo[0] != 1'b0;
            WORD:    return addr_lo[1:0] != 2'b00;
            default: return addr_lo != 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// Load data alignment: pick the addressed bytes out of a full memory word and
// sign- or zero-extend them to the data width.
module lsu_extend
    import lib_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]             data,
    input  logic [$clog2(WIDTH/8)-1:0]   offset,
    input  mem_size_t                    size,
    input  logic                         is_unsigned,
    output logic [WIDTH-1:0]             ext
);

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] keep_mask;
    logic             sign_bit;

    always_comb begin
        shifted   = data >> {offset, 3'b000};
        keep_mask = '0;
        sign_bit  = 1'b0;
        case (size)
            BYTE: begin
                keep_mask[7:0] = '1;
                sign_bit       = shifted[7];
            end
            HALF: begin
                keep_mask[15:0] = '1;
                sign_bit        = shifted[15];
            end
            WORD: begin
                keep_mask[31:0] = '1;
                sign_bit        = shifted[31];
            end
            default: begin
                keep_mask = '1;
                sign_bit  = 1'b0;
            end
        endcase
        ext = (shifted & keep_mask) | ((sign_bit && !is_unsigned) ? ~keep_mask : '0);
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one core request at a time, performs a single
// aligned data-memory access and returns aligned, extended load data.
module lsu
    import lib_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DADDR = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [1:0]         req_size,
    input  logic               req_unsigned,
    input  logic [DADDR-1:0]   req_addr,
    input  logic [WIDTH-1:0]   req_wdata,
    output logic               rsp_valid,
    output logic [WIDTH-1:0]   rsp_rdata,
    output logic               rsp_misalign,
    output logic               busy,
    output logic               dmem_req,
    input  logic               dmem_ack,
    output logic [DADDR-1:0]   dmem_addr,
    output logic [WIDTH-1:0]   dmem_wdata,
    output logic [WIDTH/8-1:0] dmem_wr_en,
    input  logic [WIDTH-1:0]   dmem_rdata
);

    localparam int NB   = WIDTH / 8;
    localparam int OFFW = $clog2(NB);

    lsu_state_t       state_reg;
    logic             we_reg;
    mem_size_t        size_reg;
    logic             uns_reg;
    logic [DADDR-1:0] addr_reg;
    logic [WIDTH-1:0] wdata_reg;
    logic [WIDTH-1:0] rdata_reg;
    logic             misalign_reg;

    logic             req_bad;
    logic [OFFW-1:0]  offset;
    logic [NB-1:0]    lane_base;
    logic [WIDTH-1:0] load_ext;

    assign req_bad = is_misaligned(req_addr[2:0], mem_size_t'(req_size))
                     || (req_size == 2'd3 && WIDTH == 32);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            we_reg       <= 1'b0;
            size_reg     <= BYTE;
            uns_reg      <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            rdata_reg    <= '0;
            misalign_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        we_reg       <= req_we;
                        size_reg     <= mem_size_t'(req_size);
                        uns_reg      <= req_unsigned;
                        addr_reg     <= req_addr;
                        wdata_reg    <= req_wdata;
                        misalign_reg <= req_bad;
                        state_reg    <= req_bad ? RESP : ACCESS;
                    end
                end
                ACCESS: begin
                    if (dmem_ack) begin
                        rdata_reg <= dmem_rdata;
                        state_reg <= RESP;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign offset    = addr_reg[OFFW-1:0];
    assign lane_base = NB'((32'd1 << (32'd1 << 32'(size_reg))) - 32'd1);

    assign req_ready    = (state_reg == IDLE);
    assign busy         = (state_reg != IDLE);
    assign dmem_req     = (state_reg == ACCESS);
    assign dmem_addr    = {addr_reg[DADDR-1:OFFW], {OFFW{1'b0}}};
    assign dmem_wr_en   = (state_reg == ACCESS && we_reg) ? (lane_base << offset) : '0;
    assign rsp_valid    = (state_reg == RESP);
    assign rsp_misalign = (state_reg == RESP) && misalign_reg;
    assign rsp_rdata    = (state_reg == RESP && !we_reg && !misalign_reg) ? load_ext : '0;

    // Each byte lane carries the store byte that would land there for any
    // legal offset of the current access size.
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
        assign dmem_wdata[gi*8 +: 8] =
            (size_reg == BYTE) ? wdata_reg[7:0] :
            (size_reg == HALF) ? wdata_reg[(gi % 2)*8 +: 8] :
            (size_reg == WORD) ? wdata_reg[(gi % 4)*8 +: 8] :
                                 wdata_reg[gi*8 +: 8];
    end

    lsu_extend #(.WIDTH(WIDTH)) u_extend (
        .data        (rdata_reg),
        .offset      (offset),
        .size        (size_reg),
        .is_unsigned (uns_reg),
        .ext         (load_ext)
    );

endmodule
